// File: rtl/secuenciador_cafe_if.sv
// -----------------------------------------------------------------------------
// secuenciador_cafe_if
// Bundles the panel inputs, the time-table request/response pair and the
// valve/status outputs of the coffee sequencer.
//   master : the sequencer (drives maquina, cafe_sel, comenzar, valvula,
//            ocupado, listo; receives cafe, iniciar, cancelar, tiempo)
//   slave  : the surroundings (panel buttons, time table, valve drivers)
// -----------------------------------------------------------------------------
interface secuenciador_cafe_if;
  logic [1:0] cafe;      // coffee selection from the panel
  logic       iniciar;   // start request, level-sampled
  logic       cancelar;  // abort request
  logic [1:0] tiempo;    // stage time in units, from the time table
  logic [2:0] maquina;   // current stage code 000..100
  logic [1:0] cafe_sel;  // latched selection fed to the time table
  logic       comenzar;  // time-table request, high only while loading
  logic [4:0] valvula;   // one-hot valve enable
  logic       ocupado;   // high whenever not idle
  logic       listo;     // drink finished

  modport master (
    input  cafe, iniciar, cancelar, tiempo,
    output maquina, cafe_sel, comenzar, valvula, ocupado, listo
  );

  modport slave (
    output cafe, iniciar, cancelar, tiempo,
    input  maquina, cafe_sel, comenzar, valvula, ocupado, listo
  );
endinterface

// File: rtl/secuenciador_cafe.sv
// -----------------------------------------------------------------------------
// secuenciador_cafe
// Steps the coffee machine through its five dispensing stages. Each stage
// first spends one CARGA cycle requesting its time from the time table, then
// holds its one-hot valve open for tiempo*SEG_POR_UNIDAD cycles. A zero time
// skips the stage. After stage 100 the block shows listo for LISTO_CICLOS.
//
// Ports:
//   clock_r : reduced clock (~1 Hz), the only clock
//   reset   : asynchronous, active-high reset
//   bus     : secuenciador_cafe_if.master (cafe, iniciar, cancelar, tiempo in;
//             maquina, cafe_sel, comenzar, valvula, ocupado, listo out)
//
// Parameters:
//   SEG_POR_UNIDAD : clock cycles per unit of tiempo (1..63)
//   LISTO_CICLOS   : cycles listo stays high (1..15)
//
// Optional feature macro: CANCELAR_EN
//   defined   : cancelar high at an edge in CARGA or DISPENSA returns to IDLE
//   undefined : cancelar is ignored, a started drink always completes
//
// All outputs are registered; they are decoded from the next-state values so
// they line up with the state they describe.
// -----------------------------------------------------------------------------
module secuenciador_cafe #(
  parameter int SEG_POR_UNIDAD = 5,
  parameter int LISTO_CICLOS   = 3
) (
  input  logic                       clock_r,
  input  logic                       reset,
  secuenciador_cafe_if.master        bus
);

  localparam int CW = $clog2(3 * SEG_POR_UNIDAD + 1);
  localparam logic [CW-1:0] SEG_W     = CW'(SEG_POR_UNIDAD);
  localparam logic [3:0]    LISTO_W   = 4'(LISTO_CICLOS);
  localparam logic [2:0]    ETAPA_ULT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CARGA    = 2'b01,
    ST_DISPENSA = 2'b10,
    ST_LISTO    = 2'b11
  } estado_t;

  estado_t       state_r, state_s;
  logic [2:0]    etapa_r, etapa_s;
  logic [CW-1:0] cuenta_r, cuenta_s;
  logic [3:0]    listo_cnt_r, listo_cnt_s;
  logic [1:0]    cafe_sel_r, cafe_sel_s;
  logic          cancel_s;

  logic [2:0]    maquina_r, maquina_s;
  logic          comenzar_r, comenzar_s;
  logic [4:0]    valvula_r, valvula_s;
  logic          ocupado_r, ocupado_s;
  logic          listo_r, listo_s;

`ifdef CANCELAR_EN
  assign cancel_s = bus.cancelar;
`else
  assign cancel_s = 1'b0;
`endif

  // Next-state, stage/counter update and output decode of the sequencer FSM.
  always_comb begin
    state_s     = state_r;
    etapa_s     = etapa_r;
    cuenta_s    = cuenta_r;
    listo_cnt_s = listo_cnt_r;
    cafe_sel_s  = cafe_sel_r;
    maquina_s   = 3'b000;
    comenzar_s  = 1'b0;
    valvula_s   = 5'b00000;
    ocupado_s   = 1'b0;
    listo_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.iniciar) begin
          cafe_sel_s = bus.cafe;
          etapa_s    = 3'b000;
          state_s    = ST_CARGA;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CARGA: begin
        if (cancel_s) begin
          state_s  = ST_IDLE;
          etapa_s  = 3'b000;
          cuenta_s = {CW{1'b0}};
        end else begin
          cuenta_s = CW'(bus.tiempo) * SEG_W;
          if (bus.tiempo == 2'b00) begin
            // Skipped stage: the next CARGA (or LISTO) follows directly.
            if (etapa_r == ETAPA_ULT) begin
              state_s     = ST_LISTO;
              listo_cnt_s = LISTO_W;
            end else begin
              etapa_s = etapa_r + 3'd1;
            end
          end else begin
            state_s = ST_DISPENSA;
          end
        end
      end
      ST_DISPENSA: begin
        if (cancel_s) begin
          state_s  = ST_IDLE;
          etapa_s  = 3'b000;
          cuenta_s = {CW{1'b0}};
        end else begin
          cuenta_s = cuenta_r - CW'(1);
          if (cuenta_r == CW'(1)) begin
            if (etapa_r == ETAPA_ULT) begin
              state_s     = ST_LISTO;
              listo_cnt_s = LISTO_W;
            end else begin
              etapa_s = etapa_r + 3'd1;
              state_s = ST_CARGA;
            end
          end else begin
            state_s = ST_DISPENSA;
          end
        end
      end
      ST_LISTO: begin
        if (listo_cnt_r == 4'd1) begin
          state_s     = ST_IDLE;
          listo_cnt_s = 4'd0;
        end else begin
          listo_cnt_s = listo_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        etapa_s     = 3'b000;
        cuenta_s    = {CW{1'b0}};
        listo_cnt_s = 4'd0;
      end
    endcase

    // Outputs describe the state being entered, so they are valid from the
    // first cycle of that state once registered.
    case (state_s)
      ST_IDLE: begin
        ocupado_s = 1'b0;
      end
      ST_CARGA: begin
        maquina_s  = etapa_s;
        comenzar_s = 1'b1;
        ocupado_s  = 1'b1;
      end
      ST_DISPENSA: begin
        maquina_s = etapa_s;
        valvula_s = 5'(5'b00001 << etapa_s);
        ocupado_s = 1'b1;
      end
      ST_LISTO: begin
        maquina_s = ETAPA_ULT;
        listo_s   = 1'b1;
        ocupado_s = 1'b1;
      end
      default: begin
        ocupado_s = 1'b0;
      end
    endcase
  end

  // State, stage, counters and registered outputs.
  always_ff @(posedge clock_r or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      etapa_r     <= 3'b000;
      cuenta_r    <= {CW{1'b0}};
      listo_cnt_r <= 4'd0;
      cafe_sel_r  <= 2'b00;
      maquina_r   <= 3'b000;
      comenzar_r  <= 1'b0;
      valvula_r   <= 5'b00000;
      ocupado_r   <= 1'b0;
      listo_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      etapa_r     <= etapa_s;
      cuenta_r    <= cuenta_s;
      listo_cnt_r <= listo_cnt_s;
      cafe_sel_r  <= cafe_sel_s;
      maquina_r   <= maquina_s;
      comenzar_r  <= comenzar_s;
      valvula_r   <= valvula_s;
      ocupado_r   <= ocupado_s;
      listo_r     <= listo_s;
    end
  end

  assign bus.maquina  = maquina_r;
  assign bus.cafe_sel = cafe_sel_r;
  assign bus.comenzar = comenzar_r;
  assign bus.valvula  = valvula_r;
  assign bus.ocupado  = ocupado_r;
  assign bus.listo    = listo_r;

endmodule

// File: doc/secuenciador_cafe.md
# secuenciador_cafe

Sequencing controller for the coffee machine: steps the machine through its five dispensing stages, drives the stage code and `comenzar` request into the per-stage time table, and captures the returned 2-bit `tiempo`. Each stage then runs a countdown on the reduced clock, with its one-hot valve output held high for the duration. The block sits between the front-panel buttons and the valve drivers, and is the sole producer of `maquina` and `comenzar`.

## Interface
Parameters:
- `SEG_POR_UNIDAD`, 5: clock_r cycles per unit of `tiempo`; legal range 1..63.
- `LISTO_CICLOS`, 3: cycles `listo` is held after the last stage; legal range 1..15.

Ports:
- `clock_r`  in  1  reduced clock, approximately 1 Hz; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cafe`  in  2  coffee selection from the panel.
- `iniciar`  in  1  start request, level-sampled.
- `cancelar`  in  1  abort request (see Configuration).
- `tiempo`  in  2  stage time in units, returned by the time table, combinational from `maquina`/`cafe_sel`/`comenzar`.
- `maquina`  out  3  current stage code, 000..100.
- `cafe_sel`  out  2  latched selection fed to the time table.
- `comenzar`  out  1  time-table request; high only in CARGA.
- `valvula`  out  5  one-hot valve enable; bit i is active while stage i dispenses.
- `ocupado`  out  1  high in every state except IDLE.
- `listo`  out  1  drink-finished indication.

## Operation
- States: IDLE, CARGA, DISPENSA, LISTO. Stage register `etapa` has width 3; counter `cuenta` has width clog2(3*SEG_POR_UNIDAD+1).
- IDLE:
  - maquina=000, comenzar=0, valvula=0, ocupado=0, listo=0.
  - When iniciar=1 at an edge: cafe_sel<=cafe, etapa<=000, go to CARGA.
- CARGA (one cycle per stage):
  - comenzar=1, maquina=etapa, valvula=0.
  - At the edge, cuenta<=tiempo*SEG_POR_UNIDAD.
  - If tiempo=00, the stage is skipped: if etapa=100 go to LISTO, else etapa<=etapa+1 and stay in CARGA.
  - Otherwise go to DISPENSA.
- DISPENSA:
  - valvula[etapa]=1, comenzar=0, maquina=etapa.
  - cuenta decrements each cycle.
  - At the edge where cuenta=1: if etapa=100 go to LISTO, else etapa<=etapa+1 and go to CARGA.
- LISTO:
  - listo=1, valvula=0, maquina=100.
  - Holds for LISTO_CICLOS cycles, then returns to IDLE.
- iniciar is ignored whenever ocupado=1. cafe changes after the start edge have no effect because cafe_sel is latched.
- Stage codes never exceed 100. etapa does not wrap; the LISTO transition occurs before any increment past 100.

## Timing
- Reset (asynchronous, immediate, mid-operation included) forces IDLE, etapa=000, cuenta=0, cafe_sel=00, and all outputs 0 with maquina=000.
- Start latency: first CARGA cycle begins 1 clock after the sampled iniciar edge.
- Stage duration: 1 + T*SEG_POR_UNIDAD cycles for a stage with T≠0; a skipped stage takes 1 cycle.
- The valve turns on the cycle after CARGA. Adjacent stage valves are separated by exactly one all-zero CARGA cycle.
- `tiempo` is sampled only on the CARGA edge. Its value in any other state is don't-care.

## Configuration
- `CANCELAR_EN` defined:
  - cancelar=1 at an edge in CARGA or DISPENSA moves to IDLE on that edge. valvula drops to 0 the next cycle, and listo is not asserted.
  - cancelar in IDLE or LISTO has no effect.
  - If cancelar and iniciar are both high in IDLE, the start proceeds.
- `CANCELAR_EN` undefined: the cancelar port exists but is ignored entirely, and a started drink always runs to LISTO.

## Test plan
- Reset mid-DISPENSA (stage 001): all outputs read 0 and maquina=000 in the same cycle, before the next edge; the block then stays in IDLE until iniciar.
- SEG_POR_UNIDAD=1, cafe=00, table returns 10,11,00,00,01 for stages 0..4:
  - valvula sequence 00001×2, 0, 00010×3, 0, 0, 0, 10000×1, then listo for 3 cycles.
  - comenzar high on exactly 5 cycles.
- SEG_POR_UNIDAD=2, cafe=11, table returns 01,01,01,10,01: per-stage valve durations are 2,2,2,4,2 cycles; total busy time is 5+12+3=20 cycles.
- iniciar held high throughout and cafe toggled mid-run: cafe_sel stays at its start value, and there is no restart until IDLE is re-entered. The second run's first CARGA occurs exactly 1 cycle after IDLE.
- With CANCELAR_EN defined, cancelar pulsed during stage 010 DISPENSA: next cycle valvula=0 and ocupado=0, and listo is never high. Without the macro, the same stimulus completes the full sequence.
